// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
//
// Counts one_minute ticks into a 24-hour BCD HH:MM time of day. A validated
// load from the key/set path replaces the time and spends one SYNC cycle
// pulsing reset_count, so the generator can restart its seconds phase.
// An invalid load is rejected with a one-cycle load_error pulse.
//
// Ports
//   clk            : system clock, all state updates on posedge
//   reset          : synchronous, active-low reset
//   one_minute     : one-cycle minute tick from the time generator
//   one_second     : one-cycle second tick from the time generator
//   load_new_time  : one-cycle request to load new_time
//   new_time       : BCD {ms_hour, ls_hour, ms_min, ls_min}
//   current_time   : BCD {ms_hour, ls_hour, ms_min, ls_min}
//   reset_count    : one-cycle pulse (the SYNC cycle) after an accepted load
//   load_error     : one-cycle pulse when a load request is rejected
//   colon          : toggles on every accepted one_second tick
//   day_rollover   : one-cycle pulse when 23:59 increments to 00:00
//   dbg_state      : FSM state, 0 = RUN, 1 = SYNC
//
// Handshake: load_new_time is a single-cycle strobe with no ready; it is
// either accepted (reset_count follows), rejected (load_error follows), or
// silently ignored when it lands in the SYNC cycle.
// ---------------------------------------------------------------------------
module time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_minute,
  input  logic        one_second,
  input  logic        load_new_time,
  input  logic [15:0] new_time,
  output logic [15:0] current_time,
  output logic        reset_count,
  output logic        load_error,
  output logic        colon,
  output logic        day_rollover,
  output logic        dbg_state
);

  typedef enum logic {
    RUN  = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_time;
  logic        r_colon;
  logic        r_reset_count;
  logic        r_load_error;
  logic        r_day_rollover;

  state_t      w_next_state;
  logic [15:0] w_next_time;
  logic        w_next_colon;
  logic        w_next_reset_count;
  logic        w_next_load_error;
  logic        w_next_day_rollover;

  logic [3:0]  w_ls_min;
  logic [3:0]  w_ms_min;
  logic [3:0]  w_ls_hour;
  logic [3:0]  w_ms_hour;
  logic [15:0] w_inc_time;
  logic        w_inc_wrap;
  logic        w_load_valid;

  assign w_ls_min  = r_time[3:0];
  assign w_ms_min  = r_time[7:4];
  assign w_ls_hour = r_time[11:8];
  assign w_ms_hour = r_time[15:12];

  // Digit-wise BCD increment with ripple carry; hour 23 wraps to 00.
  always_comb begin
    w_inc_time = r_time;
    w_inc_wrap = 1'b0;
    if (w_ls_min != 4'd9) begin
      w_inc_time[3:0] = w_ls_min + 4'd1;
    end else begin
      w_inc_time[3:0] = 4'd0;
      if (w_ms_min != 4'd5) begin
        w_inc_time[7:4] = w_ms_min + 4'd1;
      end else begin
        w_inc_time[7:4] = 4'd0;
        if (w_ms_hour == 4'd2 && w_ls_hour == 4'd3) begin
          w_inc_time[15:8] = 8'h00;
          w_inc_wrap       = 1'b1;
        end else if (w_ls_hour == 4'd9) begin
          w_inc_time[11:8]  = 4'd0;
          w_inc_time[15:12] = w_ms_hour + 4'd1;
        end else begin
          w_inc_time[11:8] = w_ls_hour + 4'd1;
        end
      end
    end
  end

  // A load is valid only if it is a real 00:00-23:59 time in BCD.
  assign w_load_valid = (new_time[3:0]   <= 4'd9) &&
                        (new_time[7:4]   <= 4'd5) &&
                        (new_time[11:8]  <= 4'd9) &&
                        (new_time[15:12] <= 4'd2) &&
                        ((new_time[15:12] != 4'd2) || (new_time[11:8] <= 4'd3));

  always_comb begin
    w_next_state        = r_state;
    w_next_time         = r_time;
    w_next_colon        = r_colon;
    w_next_reset_count  = 1'b0;
    w_next_load_error   = 1'b0;
    w_next_day_rollover = 1'b0;
    case (r_state)
      RUN: begin
        if (load_new_time && w_load_valid) begin
          // Ticks in the load cycle are dropped on purpose.
          w_next_state       = SYNC;
          w_next_time        = new_time;
          w_next_colon       = 1'b0;
          w_next_reset_count = 1'b1;
        end else begin
          w_next_load_error = load_new_time;
          if (one_minute) begin
            w_next_time         = w_inc_time;
            w_next_day_rollover = w_inc_wrap;
          end
          if (one_second) begin
            w_next_colon = ~r_colon;
          end
        end
      end
      SYNC: begin
        // Ticks and load requests are ignored while the generator resyncs.
        w_next_state = RUN;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= RUN;
      r_time         <= {INIT_HOUR, INIT_MIN};
      r_colon        <= 1'b0;
      r_reset_count  <= 1'b0;
      r_load_error   <= 1'b0;
      r_day_rollover <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_time         <= w_next_time;
      r_colon        <= w_next_colon;
      r_reset_count  <= w_next_reset_count;
      r_load_error   <= w_next_load_error;
      r_day_rollover <= w_next_day_rollover;
    end
  end

  assign current_time = r_time;
  assign reset_count  = r_reset_count;
  assign load_error   = r_load_error;
  assign colon        = r_colon;
  assign day_rollover = r_day_rollover;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter
//
// Bench for time_counter: a vector table for the directed scenarios, a
// hand-written reset-during-load sequence, then randomized traffic compared
// against a minutes-of-day reference model.
// ---------------------------------------------------------------------------
module tb_time_counter;

  logic        clk;
  logic        reset;
  logic        one_minute;
  logic        one_second;
  logic        load_new_time;
  logic [15:0] new_time;
  logic [15:0] current_time;
  logic        reset_count;
  logic        load_error;
  logic        colon;
  logic        day_rollover;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  time_counter dut (
    .clk           (clk),
    .reset         (reset),
    .one_minute    (one_minute),
    .one_second    (one_second),
    .load_new_time (load_new_time),
    .new_time      (new_time),
    .current_time  (current_time),
    .reset_count   (reset_count),
    .load_error    (load_error),
    .colon         (colon),
    .day_rollover  (day_rollover),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        ld;
    logic [15:0] nt;
    logic        mn;
    logic        sc;
    logic [15:0] t;
    logic        rc;
    logic        le;
    logic        col;
    logic        dr;
  } vec_t;

  localparam int N_VEC = 24;
  vec_t tbl[N_VEC];

  function automatic vec_t mk(logic rst_n, logic ld, logic [15:0] nt, logic mn,
                              logic sc, logic [15:0] t, logic rc, logic le,
                              logic col, logic dr);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.nt = nt; v.mn = mn; v.sc = sc;
    v.t = t; v.rc = rc; v.le = le; v.col = col; v.dr = dr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Time is held as minutes since midnight; BCD only at the boundaries.
  int   m_min;
  logic m_colon, m_rc, m_le, m_dr, m_sync;

  function automatic logic [15:0] to_bcd(int mins);
    int h, m;
    h = mins / 60;
    m = mins % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic bit bcd_ok(logic [15:0] v, output int mins);
    int d3, d2, d1, d0, h, m;
    d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
    h = d3 * 10 + d2;
    m = d1 * 10 + d1 * 0 + d0;
    m = d1 * 10 + d0;
    mins = h * 60 + m;
    return (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9) && (h < 24) && (m < 60);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int lm;
    if (!reset) begin
      m_min = 0; m_colon = 0; m_rc = 0; m_le = 0; m_dr = 0; m_sync = 0;
    end else if (m_sync) begin
      m_sync = 0; m_rc = 0; m_le = 0; m_dr = 0;
    end else if (load_new_time && bcd_ok(new_time, lm)) begin
      m_min = lm; m_colon = 0; m_rc = 1; m_le = 0; m_dr = 0; m_sync = 1;
    end else begin
      m_rc = 0;
      m_le = load_new_time;
      m_dr = 0;
      if (one_minute) begin
        m_min = (m_min + 1) % 1440;
        m_dr  = (m_min == 0);
      end
      if (one_second) m_colon = ~m_colon;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [15:0] exp_t, logic exp_rc,
                       logic exp_le, logic exp_col, logic exp_dr);
    n_checks++;
    if (current_time !== exp_t || reset_count !== exp_rc || load_error !== exp_le ||
        colon !== exp_col || day_rollover !== exp_dr) begin
      n_errors++;
      $display("FAIL %s: got time=%h rc=%b le=%b col=%b dr=%b, expected time=%h rc=%b le=%b col=%b dr=%b",
               name, current_time, reset_count, load_error, colon, day_rollover,
               exp_t, exp_rc, exp_le, exp_col, exp_dr);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic rst_n, logic ld, logic [15:0] nt, logic mn, logic sc);
    reset         = rst_n;
    load_new_time = ld;
    new_time      = nt;
    one_minute    = mn;
    one_second    = sc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; load_new_time = 1'b0; new_time = 16'h0; one_minute = 1'b0; one_second = 1'b0;
    @(posedge clk);
    #1;

    //                 rst ld  nt       mn sc   time     rc le col dr
    tbl[0]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 0, 0, 0, 0);
    tbl[2]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 0, 0, 0, 0);
    tbl[3]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 0, 0, 0, 0);
    tbl[4]  = mk(1'b1, 1'b1, 16'h2359, 1'b0, 1'b0, 16'h2359, 1, 0, 0, 0);
    tbl[5]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2359, 0, 0, 0, 0);
    tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 0, 0, 1);
    tbl[7]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 0);
    tbl[8]  = mk(1'b1, 1'b1, 16'h1959, 1'b0, 1'b0, 16'h1959, 1, 0, 0, 0);
    tbl[9]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1959, 0, 0, 0, 0);
    tbl[10] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2000, 0, 0, 0, 0);
    tbl[11] = mk(1'b1, 1'b1, 16'h0959, 1'b0, 1'b0, 16'h0959, 1, 0, 0, 0);
    tbl[12] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0959, 0, 0, 0, 0);
    tbl[13] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 0, 0, 0, 0);
    tbl[14] = mk(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1, 0, 0, 0);
    tbl[15] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 0, 0, 0, 0);
    tbl[16] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1235, 0, 0, 0, 0);
    tbl[17] = mk(1'b1, 1'b1, 16'h2400, 1'b0, 1'b0, 16'h1235, 0, 1, 0, 0);
    tbl[18] = mk(1'b1, 1'b1, 16'h1260, 1'b0, 1'b0, 16'h1235, 0, 1, 0, 0);
    // rejected load still lets that cycle's ticks through
    tbl[19] = mk(1'b1, 1'b1, 16'h0A00, 1'b1, 1'b1, 16'h1236, 0, 1, 1, 0);
    tbl[20] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1236, 0, 0, 1, 0);
    // accepted load drops both ticks and clears colon
    tbl[21] = mk(1'b1, 1'b1, 16'h0815, 1'b1, 1'b1, 16'h0815, 1, 0, 0, 0);
    // load during SYNC is ignored without error
    tbl[22] = mk(1'b1, 1'b1, 16'h1111, 1'b1, 1'b1, 16'h0815, 0, 0, 0, 0);
    tbl[23] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0815, 0, 0, 0, 0);

    for (int i = 0; i < N_VEC; i++) begin
      drive(tbl[i].rst_n, tbl[i].ld, tbl[i].nt, tbl[i].mn, tbl[i].sc);
      check($sformatf("vec%0d", i), tbl[i].t, tbl[i].rc, tbl[i].le, tbl[i].col, tbl[i].dr);
    end

    // Reset mid-count at 17:42 with colon high, while a load is requested.
    drive(1'b1, 1'b1, 16'h1742, 1'b0, 1'b0);
    check("seq_load_1742", 16'h1742, 1, 0, 0, 0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("seq_sync_1742", 16'h1742, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("seq_colon_1742", 16'h1742, 0, 0, 1, 0);
    drive(1'b0, 1'b1, 16'h0900, 1'b1, 1'b1);
    check("seq_reset", 16'h0000, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("seq_no_sync", 16'h0000, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r_n, ld, mn, sc;
      logic [15:0] nt;
      r_n = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 7) == 0);
      mn  = ($urandom_range(0, 2) == 0);
      sc  = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 2))
        0:       nt = to_bcd(int'($urandom_range(0, 1439)));
        1:       nt = to_bcd(int'($urandom_range(1435, 1439)));
        default: nt = 16'($urandom);
      endcase
      reset = r_n; load_new_time = ld; new_time = nt; one_minute = mn; one_second = sc;
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), to_bcd(m_min), m_rc, m_le, m_colon, m_dr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
